// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed after uart_rx.
// Each rising edge of wr_valid pushes wr_data into a circular FIFO. The consumer
// reads through a first-word-fall-through ready/valid port.
//
// Ports:
//   clk           system clock (same domain as uart_rx)
//   reset         synchronous active-low reset
//   wr_data       byte from uart_rx.rx_buf
//   wr_valid      uart_rx.valid; level or pulse, edge-detected here
//   rd_data       head-of-FIFO byte, 8'h00 when empty
//   rd_valid      FIFO non-empty
//   rd_ready      consumer accepts rd_data this cycle
//   count         occupancy, 0..DEPTH
//   full / empty  decoded from the registered count
//   overflow      sticky: a byte was dropped while full
//   overflow_clr  clears overflow (a same-cycle drop wins)
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CountDepth = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CountOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne     = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  overflow_q;
  logic                  wr_valid_q;

  logic wr_stb;
  logic push;
  logic pop;
  logic drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CountDepth);
  assign rd_valid = ~empty;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

  assign wr_stb = wr_valid & ~wr_valid_q;
  assign pop    = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push   = wr_stb & (~full | pop);
  assign drop   = wr_stb & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      // Set has priority over clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue-based reference model tracks
// the FIFO contents and the sticky overflow flag. A negedge monitor compares the DUT
// status and every handshaken byte against the model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          wr_data;
  logic                wr_valid;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                overflow_clr;

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted bytes in arrival order.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b0;
  bit         mon_en = 1'b0;
  bit         in_wrap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int sz;
    bit stb;
    bit pp;
    bit drp;
    sz = mq.size();
    if (!reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
    end else begin
      stb = wr_valid && !m_prev;
      pp  = (sz > 0) && rd_ready;
      drp = stb && (sz == DEPTH) && !pp;
      if (pp) void'(mq.pop_front());
      if (stb && !drp) mq.push_back(wr_data);
      if (drp) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_prev = wr_valid;
    end
  end

  always @(negedge clk) begin : monitor
    int sz;
    if (mon_en) begin
      sz = mq.size();
      chk("count", 32'(count), 32'(sz));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (sz == 0) chk("rd_data_empty", 32'(rd_data), 32'h0);
      // Handshake: the byte taken by the consumer must be the oldest accepted one.
      if (rd_valid && rd_ready && reset && sz > 0) chk("pop_data", 32'(rd_data), 32'(mq[0]));
      if (in_wrap) chk("wrap_max", 32'(count <= 3), 32'h1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    cyc();
    wr_valid = 1'b0;
    cyc();
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) cyc();
    rd_ready = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    reset = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; overflow_clr = 1'b0;
    cyc(); cyc();
    mon_en = 1'b1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    reset = 1'b1;
    cyc();

    // Basic order.
    push(8'h55); push(8'h13); push(8'h37);
    chk("basic_count", 32'(count), 32'h3);
    chk("basic_head", 32'(rd_data), 32'h55);
    drain(3);
    chk("basic_empty", 32'(empty), 32'h1);
    chk("basic_rd_data", 32'(rd_data), 32'h0);

    // Level-held valid gives exactly one push.
    wr_data = 8'hA5; wr_valid = 1'b1;
    repeat (20) cyc();
    wr_valid = 1'b0;
    cyc();
    chk("level_count", 32'(count), 32'h1);
    chk("level_data", 32'(rd_data), 32'hA5);
    drain(1);

    // Fill and overflow.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    push(8'hFF);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    drain(DEPTH);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    overflow_clr = 1'b1; cyc(); overflow_clr = 1'b0; cyc();
    chk("ovf_clr", 32'(overflow), 32'h0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    wr_data = 8'h20; wr_valid = 1'b1; rd_ready = 1'b1;
    cyc();
    wr_valid = 1'b0; rd_ready = 1'b0;
    cyc();
    chk("pp_count", 32'(count), 32'(DEPTH));
    chk("pp_ovf", 32'(overflow), 32'h0);
    chk("pp_head", 32'(rd_data), 32'h01);
    drain(DEPTH - 1);
    chk("pp_last", 32'(rd_data), 32'h20);
    drain(1);

    // Pointer wrap with occupancy held in 1..3.
    in_wrap = 1'b1;
    b = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      rd_ready = (mq.size() >= 3) || (mq.size() >= 2 && $urandom_range(0, 1) == 1);
      wr_data  = b;
      wr_valid = 1'b1;
      cyc();
      rd_ready = 1'b0;
      wr_valid = 1'b0;
      cyc();
      b = b + 8'd1;
    end
    in_wrap = 1'b0;
    drain(4);

    // Randomized traffic, including drops and clear collisions.
    for (int i = 0; i < 400; i++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_data      = 8'($urandom);
      rd_ready     = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      overflow_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    wr_valid = 1'b0; overflow_clr = 1'b0; rd_ready = 1'b0;
    cyc();

    // Reset mid-operation.
    drain(DEPTH);
    for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
    chk("mid_count5", 32'(count), 32'h5);
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    chk("mid_count", 32'(count), 32'h0);
    chk("mid_rd_valid", 32'(rd_valid), 32'h0);
    push(8'h42);
    chk("mid_data", 32'(rd_data), 32'h42);
    drain(1);

    // wr_valid high across reset release is seen as one edge.
    wr_data = 8'h99; wr_valid = 1'b1;
    reset = 1'b0; cyc(); reset = 1'b1; cyc();
    wr_valid = 1'b0; cyc();
    chk("rel_count", 32'(count), 32'h1);
    chk("rel_data", 32'(rd_data), 32'h99);
    drain(1);

    // Clear colliding with a drop: set wins.
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    wr_data = 8'hEE; wr_valid = 1'b1; overflow_clr = 1'b1;
    cyc();
    wr_valid = 1'b0; overflow_clr = 1'b0;
    cyc();
    chk("collide_ovf", 32'(overflow), 32'h1);
    chk("collide_count", 32'(count), 32'(DEPTH));
    drain(DEPTH);
    cyc();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of `uart_rx`. Captures each byte `uart_rx` presents on `rx_buf`/`valid` and stores it in a small circular FIFO. Exposes the bytes to the consumer through a first-word-fall-through ready/valid interface. Adds occupancy and full/empty status, plus a sticky overflow flag for bytes lost when the consumer stalls.

## Interface

Parameters
- `DEPTH_LOG2`, default 4: log2 of FIFO depth (DEPTH = 16 entries); legal range 1..8.

Ports
- `clk`  in  1: system clock, same domain as `uart_rx`.
- `reset`  in  1: synchronous, active-low reset; state clears on the rising `clk` edge where `reset == 0`.
- `wr_data`  in  8: byte from `uart_rx.rx_buf`.
- `wr_valid`  in  1: `uart_rx.valid`; level or pulse, edge-detected internally.
- `rd_data`  out  8: head-of-FIFO byte; `8'h00` when empty.
- `rd_valid`  out  1: FIFO non-empty.
- `rd_ready`  in  1: consumer accepts `rd_data` this cycle.
- `count`  out  DEPTH_LOG2+1: current occupancy, 0..DEPTH.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.
- `overflow_clr`  in  1: clears `overflow`.

## Operation

- **Write strobe.** `wr_stb = wr_valid & ~wr_valid_q`, where `wr_valid_q` is `wr_valid` registered.
  - Exactly one push per rising edge of `wr_valid`, however long `valid` stays high.
- **Pop.** `pop = rd_valid & rd_ready`.
  - `rd_ready` while empty has no effect.
- **Push acceptance.** `push = wr_stb & (~full | pop)`.
  - When full, a simultaneous pop frees the slot and the byte is accepted.
- **Drop.** `drop = wr_stb & full & ~pop`.
  - The byte is discarded.
  - No pointer or count change.
  - `overflow` is set.
- **Storage.** Register array `mem[DEPTH]`, with `wr_ptr`/`rd_ptr` each DEPTH_LOG2 bits wide.
  - Pointers wrap modulo DEPTH naturally, with no special-case logic.
  - Push: `mem[wr_ptr] <= wr_data`, `wr_ptr <= wr_ptr + 1`.
  - Pop: `rd_ptr <= rd_ptr + 1`.
- **Count.**
  - Push only: +1.
  - Pop only: −1.
  - Both or neither: unchanged.
  - Never exceeds DEPTH; never underflows.
- **Read data.** `rd_data = empty ? 8'h00 : mem[rd_ptr]`, an asynchronous array read (FWFT).
- **Status outputs.** `rd_valid = ~empty`. `full` and `empty` are decoded from the registered `count`.
- **Overflow flag.**
  - Set by `drop`.
  - Cleared by `overflow_clr`.
  - If set and clear occur in the same cycle, set wins.
- **Reset (`reset == 0` at a `clk` edge).**
  - `wr_ptr`, `rd_ptr`, `count`, `overflow`, `wr_valid_q` → 0.
  - `mem` is not cleared.
  - Outputs after reset: `rd_valid=0`, `empty=1`, `full=0`, `count=0`, `overflow=0`, `rd_data=8'h00`.
  - Reset mid-operation discards all stored bytes.
  - If `wr_valid` is high across reset release, the edge detector reads it as a rising edge. That byte is pushed once, in the first cycle after release.

## Timing

- Write latency: `wr_valid` rises in cycle N (sampled at edge N) → `rd_valid=1` and `rd_data` valid in cycle N+1.
- The detected edge is pushed at the same clock edge it is sampled on, so no extra delay stage.
- Pop: with `rd_valid & rd_ready` high at edge M, `rd_data` shows the next entry (or `8'h00`/`rd_valid=0` if now empty) in cycle M+1.
- Sustained throughput: one pop per cycle. Push rate is limited by `wr_valid` edges, at most one per 2 cycles.
- `count`, `full`, `empty`, `overflow` update one edge after the causing event. No combinational path from `wr_valid` to any output.
- Simultaneous push and pop:
  - Empty FIFO: push only, since pop requires `rd_valid`.
  - Full FIFO: both occur, count stays DEPTH, no overflow.

## Test plan

- **Reset and basic order.**
  - Stimulus: hold `reset=0` 2 cycles, release. Pulse `wr_valid` with 0x55, 0x13, 0x37, `rd_ready=0`.
  - Required: `count=3`; `rd_data=0x55`. Then `rd_ready=1` for 3 cycles → 0x55, 0x13, 0x37 in order; `empty=1`, `rd_data=0x00`.
- **Level-held valid.**
  - Stimulus: hold `wr_valid=1` with `wr_data=0xA5` for 20 cycles.
  - Required: exactly one entry, `count=1`.
- **Fill and overflow.**
  - Stimulus: push 16 bytes 0x00..0x0F with no reads, then push 0xFF.
  - Required:
    - `full=1`, `count=16` after the 16th push.
    - 0xFF dropped; `overflow=1`, `count=16`.
    - Draining returns 0x00..0x0F; `overflow` stays 1 until `overflow_clr`.
- **Simultaneous push/pop when full.**
  - Stimulus: with the FIFO full of 0x00..0x0F and `rd_ready=1`, push 0x20 in the same cycle as a pop.
  - Required: 0x00 popped, 0x20 accepted, `count=16`, `overflow=0`. Drain ends with 0x20.
- **Pointer wrap.**
  - Stimulus: 40 interleaved push/pop of an incrementing byte, keeping occupancy 1..3.
  - Required: output sequence equals input sequence; `count` never exceeds 3.
- **Reset mid-operation and clear/set collision.**
  - Stimulus: with 5 entries stored, assert `reset=0` one cycle.
  - Required: `count=0`, `rd_valid=0`; the next push of 0x42 reads back 0x42.
  - Separately: `overflow_clr` in the same cycle as a drop leaves `overflow=1`.
